// File: rtl/gray_pkg.sv
// Gray-code conversion helpers shared by the counter and FIFO pointer-sync logic.
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 32;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended inputs convert correctly: the upper zero bits contribute nothing.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-coded copy, Gray load port,
// optional saturation and wrap/limit status. count_gray comes straight from
// flops so it can be synchronised into another clock domain.
module gray_counter
  import gray_pkg::*;
#(
  parameter int          WIDTH    = 4,
  parameter int unsigned INIT     = 0,
  parameter int          SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] count_bin,
  output logic [WIDTH-1:0] count_gray,
  output logic [WIDTH-1:0] count_gray_next,
  output logic             wrap,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] ALL_ONES  = '1;
  localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] INIT_GRAY = WIDTH'(bin2gray(32'(INIT_BIN)));
  localparam bit               SAT_EN    = (SATURATE != 0);

  if ((WIDTH < 2) || (WIDTH > GRAY_MAX_WIDTH)) begin : g_bad_width
    $error("gray_counter: WIDTH must be in 2..32");
  end
  if ((WIDTH < 32) && (64'(INIT) >= (64'd1 << WIDTH))) begin : g_bad_init
    $error("gray_counter: INIT does not fit in WIDTH bits");
  end

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic [WIDTH-1:0] w_next_bin;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_wrap_next;
  logic             w_at_limit;

  // Limit depends on the live direction input, so it is valid before the edge.
  always_comb begin
    w_at_limit = up ? (r_bin == ALL_ONES) : (r_bin == '0);
  end

  // Next-value selection; reset is folded in so count_gray_next reflects INIT too.
  always_comb begin
    w_next_bin  = r_bin;
    w_wrap_next = 1'b0;
    if (!reset_n) begin
      w_next_bin = INIT_BIN;
    end else if (load) begin
      w_next_bin = WIDTH'(gray2bin(32'(load_gray)));
    end else if (enable) begin
      if (w_at_limit) begin
        if (!SAT_EN) begin
          w_next_bin  = up ? '0 : ALL_ONES;
          w_wrap_next = 1'b1;
        end
      end else begin
        w_next_bin = up ? (r_bin + 1'b1) : (r_bin - 1'b1);
      end
    end
    w_next_gray = WIDTH'(bin2gray(32'(w_next_bin)));
  end

  // Binary, Gray and wrap all register on the same edge so there is no skew.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bin  <= INIT_BIN;
      r_gray <= INIT_GRAY;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_next_bin;
      r_gray <= w_next_gray;
      r_wrap <= w_wrap_next;
    end
  end

  assign count_bin       = r_bin;
  assign count_gray      = r_gray;
  assign count_gray_next = w_next_gray;
  assign wrap            = r_wrap;
  assign at_limit        = w_at_limit;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench: the driver pushes expected post-edge state, a monitor pops
// and compares after each rising edge. Three instances: wrapping 4-bit
// (INIT=5), saturating 4-bit (INIT=5) sharing its stimulus, and wrapping 7-bit.
module tb_gray_counter;

  typedef struct {
    logic [3:0] bw;
    logic       ww;
    logic [3:0] bs;
    logic       ws;
    logic [6:0] b7;
    logic       w7;
    bit         onebit;
    logic [3:0] pg;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n, enable, up, load;
  logic [3:0] load_gray;
  logic e7, u7, l7;
  logic [6:0] lg7;

  logic [3:0] bin_w, gray_w, gnext_w, bin_s, gray_s, gnext_s;
  logic [6:0] bin_7, gray_7, gnext_7;
  logic wrap_w, lim_w, wrap_s, lim_s, wrap_7, lim_7;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  int unsigned m_w, m_s, m_7;
  logic [3:0] gseq [16];

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4), .INIT(5), .SATURATE(0)) dut_w (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .load(load),
    .load_gray(load_gray), .count_bin(bin_w), .count_gray(gray_w),
    .count_gray_next(gnext_w), .wrap(wrap_w), .at_limit(lim_w));

  gray_counter #(.WIDTH(4), .INIT(5), .SATURATE(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .load(load),
    .load_gray(load_gray), .count_bin(bin_s), .count_gray(gray_s),
    .count_gray_next(gnext_s), .wrap(wrap_s), .at_limit(lim_s));

  gray_counter #(.WIDTH(7), .INIT(0), .SATURATE(0)) dut_7 (
    .clk(clk), .reset_n(reset_n), .enable(e7), .up(u7), .load(l7),
    .load_gray(lg7), .count_bin(bin_7), .count_gray(gray_7),
    .count_gray_next(gnext_7), .wrap(wrap_7), .at_limit(lim_7));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned m_b2g(input int unsigned b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned m_g2b(input int unsigned g, input int w);
    int unsigned b = g;
    for (int s = 1; s < w; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic bit m_lim(input int unsigned cur, input bit u, input int w);
    return u ? (cur == (32'd1 << w) - 1) : (cur == 0);
  endfunction

  function automatic int unsigned m_next(input int unsigned cur, input bit rst, en, u, ld,
                                         input int unsigned lg, input int w, input bit sat,
                                         input int unsigned init);
    int unsigned mx = (32'd1 << w) - 1;
    if (rst) return init;
    if (ld) return m_g2b(lg, w);
    if (!en) return cur;
    if (sat && m_lim(cur, u, w)) return cur;
    return u ? ((cur + 1) & mx) : ((cur - 1) & mx);
  endfunction

  function automatic bit m_wrap(input int unsigned cur, input bit rst, en, u, ld,
                                input int w, input bit sat);
    return !rst && !sat && en && !ld && m_lim(cur, u, w);
  endfunction

  task automatic step(input bit rst, en, u, ld, input logic [3:0] lg,
                      input bit en7, up7, ld7, input logic [6:0] lgv7);
    exp_t e;
    @(negedge clk);
    reset_n = !rst; enable = en; up = u; load = ld; load_gray = lg;
    e7 = en7; u7 = up7; l7 = ld7; lg7 = lgv7;
    #1;
    chk("at_limit_w", lim_w, m_lim(m_w, u, 4));
    chk("at_limit_s", lim_s, m_lim(m_s, u, 4));
    chk("at_limit_7", lim_7, m_lim(m_7, up7, 7));
    e.ww = m_wrap(m_w, rst, en, u, ld, 4, 1'b0);
    e.ws = m_wrap(m_s, rst, en, u, ld, 4, 1'b1);
    e.w7 = m_wrap(m_7, rst, en7, up7, ld7, 7, 1'b0);
    e.pg = 4'(m_b2g(m_w));
    e.onebit = !rst && !ld && en;
    m_w = m_next(m_w, rst, en, u, ld, lg, 4, 1'b0, 5);
    m_s = m_next(m_s, rst, en, u, ld, lg, 4, 1'b1, 5);
    m_7 = m_next(m_7, rst, en7, up7, ld7, lgv7, 7, 1'b0, 0);
    e.bw = 4'(m_w); e.bs = 4'(m_s); e.b7 = 7'(m_7);
    chk("gray_next_w", gnext_w, m_b2g(m_w));
    chk("gray_next_s", gnext_s, m_b2g(m_s));
    chk("gray_next_7", gnext_7, m_b2g(m_7));
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: each rising edge presents one new state; compare it to the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("bin_w", bin_w, e.bw);
        chk("gray_w", gray_w, m_b2g(e.bw));
        chk("wrap_w", wrap_w, e.ww);
        chk("bin_s", bin_s, e.bs);
        chk("gray_s", gray_s, m_b2g(e.bs));
        chk("wrap_s", wrap_s, e.ws);
        chk("bin_7", bin_7, e.b7);
        chk("gray_7", gray_7, m_b2g(e.b7));
        chk("wrap_7", wrap_7, e.w7);
        if (e.onebit) chk("gray_w_onebit", $countones(gray_w ^ e.pg), 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cnt;
    gseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    reset_n = 1'b0; enable = 1'b0; up = 1'b1; load = 1'b0; load_gray = '0;
    e7 = 1'b0; u7 = 1'b1; l7 = 1'b0; lg7 = '0;
    m_w = 5; m_s = 5; m_7 = 0;

    // Reset wins over load and enable
    step(1, 1, 1, 1, 4'b1111, 1, 1, 1, 7'h55);
    step(1, 1, 1, 1, 4'b1111, 1, 1, 1, 7'h55);
    chk("rst_bin", bin_w, 5);
    chk("rst_gray", gray_w, 4'b0111);
    chk("rst_wrap", wrap_w, 0);
    chk("rst_bin7", bin_7, 0);

    // Up-count from 0 through the wrap; saturating copy sticks at 15
    step(0, 0, 1, 1, 4'b0000, 0, 1, 0, 7'h0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 1, 0, 4'b0000, 1, 1, 0, 7'h0);
      chk("up_seq_gray", gray_w, gseq[(i + 1) % 16]);
      chk("up_seq_wrap", wrap_w, (i == 15));
    end
    chk("sat_up_bin", bin_s, 15);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 4'b0000, 1, 0, 0, 7'h0);
      chk("sat_hold_15", bin_s, 15);
      chk("sat_no_wrap", wrap_s, 0);
    end

    // Down-count wrap from 0; saturating copy sticks at 0
    step(0, 0, 0, 1, 4'b0000, 0, 0, 1, 7'h0);
    @(negedge clk); up = 1'b0; enable = 1'b0; #1;
    chk("at_limit_zero_down", lim_w, 1);
    step(0, 1, 0, 0, 4'b0000, 1, 0, 0, 7'h0);
    chk("down_wrap_bin", bin_w, 15);
    chk("down_wrap_gray", gray_w, 4'b1000);
    chk("down_wrap_pulse", wrap_w, 1);
    chk("down_wrap_bin7", bin_7, 127);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 7'h0);
      chk("sat_hold_0", bin_s, 0);
    end
    chk("wrap_single_cycle", wrap_w, 0);

    // Load overrides enable, then count continues from the loaded value
    step(0, 0, 1, 1, 4'b0010, 0, 1, 0, 7'h0);
    chk("load_3", bin_w, 3);
    step(0, 1, 1, 1, 4'b1101, 0, 1, 0, 7'h0);
    chk("load_pri_bin", bin_w, 9);
    chk("load_pri_wrap", wrap_w, 0);
    step(0, 1, 1, 0, 4'b0000, 0, 1, 0, 7'h0);
    chk("after_load_bin", bin_w, 10);
    chk("after_load_gray", gray_w, 4'b1111);

    // Mid-count reset
    step(1, 1, 1, 0, 4'b0000, 1, 1, 0, 7'h0);
    chk("midrst_bin", bin_w, 5);

    // Mixed traffic against the bench model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0, 4'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0, 7'($urandom));
    end

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #3;
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
